// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, drives an async-read instruction memory,
// and buffers fetched words in a small prefetch queue presented to decode via valid/ready.
`timescale 1ns/1ps
module fetch_controller #(
   parameter int                ADDR_W   = 9,
   parameter int                INST_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic              fault
);

   localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]  FULL  = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {FETCH, HALTED, FAULT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [INST_W-1:0] inst_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    count;
   logic              deq;
   logic              push;

   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign out_inst  = out_valid ? inst_q[rd_ptr] : '0;
   assign out_pc    = out_valid ? pc_q[rd_ptr]   : '0;

   // halt is sampled before the enqueue decision, so the halting edge never pushes
   assign deq  = out_valid && out_ready;
   assign push = (state == FETCH) && !redirect_valid && !halt && ((count < FULL) || deq);

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fault    <= 1'b0;
      end else begin
         case (state)
            FAULT: ;
            default: begin
               if (redirect_valid) begin
                  // Redirect wins over enqueue/dequeue; the queue is emptied either way
                  rd_ptr <= '0;
                  wr_ptr <= '0;
                  count  <= '0;
                  if (redirect_pc[0]) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     fetch_pc <= redirect_pc;
                     state    <= ((state == FETCH) && !halt) ? FETCH : HALTED;
                  end
               end else begin
                  if (deq)
                     rd_ptr <= rd_ptr + 1'b1;
                  if (push) begin
                     wr_ptr   <= wr_ptr + 1'b1;
                     fetch_pc <= fetch_pc + ADDR_W'(2);
                  end
                  if (push && !deq)
                     count <= count + 1'b1;
                  else if (!push && deq)
                     count <= count - 1'b1;
                  state <= halt ? HALTED : FETCH;
               end
            end
         endcase
      end
   end

   // NOTE: queue storage has no reset; entries are only observable while count says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_q[wr_ptr] <= imem_inst;
         pc_q[wr_ptr]   <= fetch_pc;
      end
   end

endmodule
